// File: rtl/ser_load_strobe.sv
// rtl/ser_load_strobe.sv - framed serial addr+data loader driving a transparent-latch bank
// Optional PARITY_EN: one even-parity bit follows the data field.
module ser_load_strobe #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int NREG   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame,
  input  logic              bit_stb,
  input  logic              sdata,
  output logic [NREG-1:0]   ld_en,
  output logic [DATA_W-1:0] ld_d,
  output logic              busy,
  output logic              err
);
  localparam int CNT_W = (DATA_W > ADDR_W) ? $clog2(DATA_W) : $clog2(ADDR_W);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W:0]   NREG_L    = (ADDR_W + 1)'(NREG);
  localparam logic [NREG-1:0]   ONE_HOT0  = NREG'(1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, PAR, LOAD, WAIT} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [ADDR_W-1:0] addr_sr;
  logic [DATA_W-1:0] data_sr;
  logic [DATA_W-1:0] word_data;
  logic              abort, word_done, word_ok;

  // word_data/word_ok describe the word as it stands once the final bit is taken
`ifdef PARITY_EN
  assign word_data = data_sr;
  assign word_ok   = ({1'b0, addr_sr} < NREG_L) && !(^{addr_sr, data_sr, sdata});
`else
  assign word_data = {data_sr[DATA_W-2:0], sdata};
  assign word_ok   = ({1'b0, addr_sr} < NREG_L);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    abort     = 1'b0;
    word_done = 1'b0;
    case (state)
      IDLE: if (frame) begin
        state_nx = ADDR;
        cnt_nx   = '0;
      end
      ADDR: if (!frame) begin
        abort    = 1'b1;
        state_nx = IDLE;
      end else if (bit_stb) begin
        if (cnt == ADDR_LAST) begin
          state_nx = DATA;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      DATA: if (!frame) begin
        abort    = 1'b1;
        state_nx = IDLE;
      end else if (bit_stb) begin
        if (cnt == DATA_LAST) begin
          cnt_nx = '0;
`ifdef PARITY_EN
          state_nx = PAR;
`else
          state_nx  = LOAD;
          word_done = 1'b1;
`endif
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
`ifdef PARITY_EN
      PAR: if (!frame) begin
        abort    = 1'b1;
        state_nx = IDLE;
      end else if (bit_stb) begin
        state_nx  = LOAD;
        word_done = 1'b1;
      end
`endif
      LOAD: state_nx = WAIT;
      WAIT: if (!frame) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ld_en/ld_d are registered on the edge that takes the last bit, so they appear in LOAD
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_sr <= '0;
      data_sr <= '0;
      ld_en   <= '0;
      ld_d    <= '0;
      err     <= 1'b0;
    end else begin
      ld_en <= '0;
      err   <= abort;
      if (frame && bit_stb && state == ADDR) addr_sr <= {addr_sr[ADDR_W-2:0], sdata};
      if (frame && bit_stb && state == DATA) data_sr <= {data_sr[DATA_W-2:0], sdata};
      if (word_done) begin
        if (word_ok) begin
          ld_en <= ONE_HOT0 << addr_sr;
          ld_d  <= word_data;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == ADDR) || (state == DATA) || (state == PAR) || (state == LOAD);

endmodule
